// File: rtl/axi4lm_pkg.sv
// Shared response codes and FSM state types for the queued AXI4-Lite master.
package axi4lm_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_WAIT}         r_state_t;

endpackage

// File: rtl/amci_cmd_fifo.sv
// First-word-fall-through synchronous command FIFO; DEPTH must be a power of two.
module amci_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign pop_data = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi4_lite_master_q.sv
// Queued AXI4-Lite master with independent read/write channels and in-order responses.
// Optional stall watchdog enabled by defining AXI4LM_TIMEOUT_EN.
module axi4_lite_master_q
  import axi4lm_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   wr_cmd_addr,
  input  logic [DW-1:0]   wr_cmd_data,
  input  logic [DW/8-1:0] wr_cmd_strb,
  input  logic            wr_cmd_valid,
  output logic            wr_cmd_ready,
  output logic [1:0]      wr_resp,
  output logic            wr_resp_valid,
  output logic            wr_idle,
  input  logic [AW-1:0]   rd_cmd_addr,
  input  logic            rd_cmd_valid,
  output logic            rd_cmd_ready,
  output logic [DW-1:0]   rd_data,
  output logic [1:0]      rd_resp,
  output logic            rd_resp_valid,
  output logic            rd_idle,
  output logic            timeout_err,
  output logic [AW-1:0]   AXI_AWADDR,
  output logic            AXI_AWVALID,
  input  logic            AXI_AWREADY,
  output logic [DW-1:0]   AXI_WDATA,
  output logic [DW/8-1:0] AXI_WSTRB,
  output logic            AXI_WVALID,
  input  logic            AXI_WREADY,
  input  logic [1:0]      AXI_BRESP,
  input  logic            AXI_BVALID,
  output logic            AXI_BREADY,
  output logic [AW-1:0]   AXI_ARADDR,
  output logic            AXI_ARVALID,
  input  logic            AXI_ARREADY,
  input  logic [DW-1:0]   AXI_RDATA,
  input  logic [1:0]      AXI_RRESP,
  input  logic            AXI_RVALID,
  output logic            AXI_RREADY
);

  localparam int SW  = DW / 8;
  localparam int WFW = AW + DW + SW;

  w_state_t       w_state;
  r_state_t       r_state;
  logic [WFW-1:0] wf_dout;
  logic [AW-1:0]  rf_dout;
  logic           wf_full, wf_empty, wf_pop;
  logic           rf_full, rf_empty, rf_pop;
  logic           aw_fire, w_fire;

`ifdef AXI4LM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] w_cnt, r_cnt;
  logic          w_to, r_to;
  logic          w_to_err, r_to_err;

  assign w_to        = (w_cnt == TW'(TIMEOUT - 1));
  assign r_to        = (r_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = w_to_err | r_to_err;
`else
  // Watchdog compiled out: the flag is a constant 0 and TIMEOUT has no effect.
  assign timeout_err = (TIMEOUT < 0);
`endif

  amci_cmd_fifo #(.WIDTH(WFW), .DEPTH(QDEPTH)) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_cmd_valid),
    .push_data ({wr_cmd_addr, wr_cmd_data, wr_cmd_strb}),
    .full      (wf_full),
    .pop       (wf_pop),
    .pop_data  (wf_dout),
    .empty     (wf_empty)
  );

  amci_cmd_fifo #(.WIDTH(AW), .DEPTH(QDEPTH)) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_cmd_valid),
    .push_data (rd_cmd_addr),
    .full      (rf_full),
    .pop       (rf_pop),
    .pop_data  (rf_dout),
    .empty     (rf_empty)
  );

  assign wr_cmd_ready = !wf_full;
  assign rd_cmd_ready = !rf_full;
  assign wf_pop       = (w_state == W_IDLE) && !wf_empty;
  assign rf_pop       = (r_state == R_IDLE) && !rf_empty;
  assign wr_idle      = wf_empty && (w_state == W_IDLE);
  assign rd_idle      = rf_empty && (r_state == R_IDLE);
  assign aw_fire      = AXI_AWVALID && AXI_AWREADY;
  assign w_fire       = AXI_WVALID && AXI_WREADY;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state       <= W_IDLE;
      AXI_AWADDR    <= '0;
      AXI_WDATA     <= '0;
      AXI_WSTRB     <= '0;
      AXI_AWVALID   <= 1'b0;
      AXI_WVALID    <= 1'b0;
      AXI_BREADY    <= 1'b0;
      wr_resp       <= RESP_OKAY;
      wr_resp_valid <= 1'b0;
`ifdef AXI4LM_TIMEOUT_EN
      w_cnt         <= '0;
      w_to_err      <= 1'b0;
`endif
    end else begin
      wr_resp_valid <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (!wf_empty) begin
            {AXI_AWADDR, AXI_WDATA, AXI_WSTRB} <= wf_dout;
            AXI_AWVALID <= 1'b1;
            AXI_WVALID  <= 1'b1;
            AXI_BREADY  <= 1'b1;
            w_state     <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (aw_fire) AXI_AWVALID <= 1'b0;
          if (w_fire)  AXI_WVALID  <= 1'b0;
          if ((aw_fire || !AXI_AWVALID) && (w_fire || !AXI_WVALID)) w_state <= W_RESP;
        end
        W_RESP: begin
          if (AXI_BVALID) begin
            AXI_BREADY    <= 1'b0;
            wr_resp       <= AXI_BRESP;
            wr_resp_valid <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
`ifdef AXI4LM_TIMEOUT_EN
      // Abort overrides the normal transition when the slave never finishes.
      if (w_state == W_IDLE) begin
        w_cnt <= '0;
      end else if (w_to && !(w_state == W_RESP && AXI_BVALID)) begin
        AXI_AWVALID   <= 1'b0;
        AXI_WVALID    <= 1'b0;
        AXI_BREADY    <= 1'b0;
        wr_resp       <= RESP_DECERR;
        wr_resp_valid <= 1'b1;
        w_to_err      <= 1'b1;
        w_state       <= W_IDLE;
      end else begin
        w_cnt <= w_cnt + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= R_IDLE;
      AXI_ARADDR    <= '0;
      AXI_ARVALID   <= 1'b0;
      AXI_RREADY    <= 1'b0;
      rd_data       <= '0;
      rd_resp       <= RESP_OKAY;
      rd_resp_valid <= 1'b0;
`ifdef AXI4LM_TIMEOUT_EN
      r_cnt         <= '0;
      r_to_err      <= 1'b0;
`endif
    end else begin
      rd_resp_valid <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (!rf_empty) begin
            AXI_ARADDR  <= rf_dout;
            AXI_ARVALID <= 1'b1;
            AXI_RREADY  <= 1'b1;
            r_state     <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (AXI_ARREADY) AXI_ARVALID <= 1'b0;
          if (AXI_RVALID) begin
            AXI_RREADY    <= 1'b0;
            rd_data       <= AXI_RDATA;
            rd_resp       <= AXI_RRESP;
            rd_resp_valid <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
`ifdef AXI4LM_TIMEOUT_EN
      if (r_state == R_IDLE) begin
        r_cnt <= '0;
      end else if (r_to && !AXI_RVALID) begin
        AXI_ARVALID   <= 1'b0;
        AXI_RREADY    <= 1'b0;
        rd_resp       <= RESP_DECERR;
        rd_resp_valid <= 1'b1;
        r_to_err      <= 1'b1;
        r_state       <= R_IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_q.sv
// Directed bench for axi4_lite_master_q with a small AXI4-Lite slave model.
module tb_axi4_lite_master_q;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] wr_cmd_addr, rd_cmd_addr;
  logic [DW-1:0] wr_cmd_data;
  logic [3:0]    wr_cmd_strb;
  logic          wr_cmd_valid, wr_cmd_ready, rd_cmd_valid, rd_cmd_ready;
  logic [1:0]    wr_resp, rd_resp;
  logic          wr_resp_valid, rd_resp_valid, wr_idle, rd_idle, timeout_err;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] AXI_AWADDR, AXI_ARADDR;
  logic          AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [DW-1:0] AXI_WDATA, AXI_RDATA;
  logic [3:0]    AXI_WSTRB;
  logic [1:0]    AXI_BRESP, AXI_RRESP;
  logic          AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;

  axi4_lite_master_q #(.DW(DW), .AW(AW), .QDEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_data(wr_cmd_data), .wr_cmd_strb(wr_cmd_strb),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_resp(wr_resp), .wr_resp_valid(wr_resp_valid), .wr_idle(wr_idle),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_data(rd_data), .rd_resp(rd_resp), .rd_resp_valid(rd_resp_valid), .rd_idle(rd_idle),
    .timeout_err(timeout_err),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  always #5 clk = ~clk;

  // Slave model: registers the write, issues B the cycle after it has both AW and W;
  // R is issued the cycle after the AR handshake.
  logic        aw_rdy, w_rdy, ar_rdy, b_hold;
  logic [1:0]  sresp_cfg;
  logic [31:0] mem [64];
  logic        got_aw, got_w;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  assign AXI_AWREADY = aw_rdy;
  assign AXI_WREADY  = w_rdy;
  assign AXI_ARREADY = ar_rdy;

  always @(posedge clk) begin
    if (reset) begin
      got_aw <= 1'b0; got_w <= 1'b0; AXI_BVALID <= 1'b0; AXI_RVALID <= 1'b0;
      AXI_BRESP <= 2'b00; AXI_RRESP <= 2'b00; AXI_RDATA <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (AXI_AWVALID && AXI_AWREADY) begin got_aw <= 1'b1; s_awaddr <= AXI_AWADDR; end
      if (AXI_WVALID && AXI_WREADY) begin got_w <= 1'b1; s_wdata <= AXI_WDATA; s_wstrb <= AXI_WSTRB; end
      if (got_aw && got_w && !AXI_BVALID && !b_hold) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        AXI_BVALID <= 1'b1; AXI_BRESP <= sresp_cfg; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (AXI_BVALID && AXI_BREADY) AXI_BVALID <= 1'b0;
      if (AXI_ARVALID && AXI_ARREADY) begin
        AXI_RVALID <= 1'b1; AXI_RDATA <= mem[AXI_ARADDR[7:2]]; AXI_RRESP <= sresp_cfg;
      end else if (AXI_RVALID && AXI_RREADY) AXI_RVALID <= 1'b0;
    end
  end

  int cyc = 0;
  int wr_pulses = 0, rd_pulses = 0, b_hs = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (wr_resp_valid) wr_pulses <= wr_pulses + 1;
      if (rd_resp_valid) rd_pulses <= rd_pulses + 1;
      if (AXI_BVALID && AXI_BREADY) b_hs <= b_hs + 1;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
    bit r;
    ok = 0;
    wr_cmd_addr = a; wr_cmd_data = d; wr_cmd_strb = s; wr_cmd_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = wr_cmd_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    wr_cmd_valid = 1'b0;
  endtask

  task automatic push_rd(input logic [31:0] a, output bit ok);
    bit r;
    ok = 0;
    rd_cmd_addr = a; rd_cmd_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = rd_cmd_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    rd_cmd_valid = 1'b0;
  endtask

  // Issues one command and waits for its response; lat counts edges from acceptance.
  task automatic run_cmd(input bit is_wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int lat, output logic [1:0] resp, output logic [31:0] rdat,
                         output bit vld_n1, output bit one_cyc);
    bit ok, got;
    int acc;
    if (is_wr) push_wr(a, d, s, ok); else push_rd(a, ok);
    acc = cyc;
    @(posedge clk); #1;
    vld_n1 = is_wr ? (AXI_AWVALID && AXI_WVALID) : AXI_ARVALID;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (is_wr ? wr_resp_valid : rd_resp_valid) begin got = 1; break; end
      @(posedge clk); #1;
    end
    lat  = (ok && got) ? cyc - acc : -1;
    resp = is_wr ? wr_resp : rd_resp;
    rdat = rd_data;
    @(posedge clk); #1;
    one_cyc = !(is_wr ? wr_resp_valid : rd_resp_valid);
  endtask

  task automatic wait_rd(output bit got);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rd_resp_valid) begin got = 1; break; end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  sresp;
    logic [1:0]  eresp;
    logic [31:0] edata;
  } vec_t;

  initial begin
    vec_t        vt [10];
    int          lat, wl, rl, acc, n, wp0, bh0;
    logic [1:0]  resp;
    logic [31:0] rdat, rv;
    bit          vn1, oc, ok, got;

    vt[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 2'd0, 2'd0, 32'h0};
    vt[1] = '{1, 32'h14, 32'h12345678, 4'h3, 2'd0, 2'd0, 32'h0};
    vt[2] = '{1, 32'h18, 32'hAABBCCDD, 4'hA, 2'd0, 2'd0, 32'h0};
    vt[3] = '{0, 32'h10, 32'h0,        4'h0, 2'd0, 2'd0, 32'hDEADBEEF};
    vt[4] = '{0, 32'h14, 32'h0,        4'h0, 2'd0, 2'd0, 32'h00005678};
    vt[5] = '{0, 32'h18, 32'h0,        4'h0, 2'd0, 2'd0, 32'hAA00CC00};
    vt[6] = '{1, 32'h10, 32'h00000011, 4'h1, 2'd0, 2'd0, 32'h0};
    vt[7] = '{0, 32'h10, 32'h0,        4'h0, 2'd0, 2'd0, 32'hDEADBE11};
    vt[8] = '{1, 32'h1C, 32'hFFFFFFFF, 4'h0, 2'd2, 2'd2, 32'h0};
    vt[9] = '{0, 32'h1C, 32'h0,        4'h0, 2'd2, 2'd2, 32'h0};

    reset = 1'b1; wr_cmd_valid = 0; rd_cmd_valid = 0;
    wr_cmd_addr = '0; wr_cmd_data = '0; wr_cmd_strb = '0; rd_cmd_addr = '0;
    aw_rdy = 1; w_rdy = 1; ar_rdy = 1; b_hold = 0; sresp_cfg = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_valids", {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
    chk("rst_cmd_ready", {wr_cmd_ready, rd_cmd_ready}, 2'b11);
    chk("rst_idle", {wr_idle, rd_idle}, 2'b11);
    chk("rst_resp", {wr_resp_valid, rd_resp_valid, wr_resp, rd_resp, timeout_err}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_addr_data", {AXI_AWADDR, AXI_WDATA, AXI_WSTRB, AXI_ARADDR}, 0);

    for (int i = 0; i < 10; i++) begin
      sresp_cfg = vt[i].sresp;
      run_cmd(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, lat, resp, rdat, vn1, oc);
      chk($sformatf("v%0d_valid_n1", i), vn1, 1);
      chk($sformatf("v%0d_latency", i), lat, vt[i].wr ? 4 : 3);
      chk($sformatf("v%0d_resp", i), resp, vt[i].eresp);
      chk($sformatf("v%0d_pulse_1cyc", i), oc, 1);
      if (!vt[i].wr) chk($sformatf("v%0d_rdata", i), rdat, vt[i].edata);
    end
    sresp_cfg = 2'd0;
    chk("idle_after_table", {wr_idle, rd_idle}, 2'b11);

    // WREADY held off for 3 cycles after the AW handshake.
    w_rdy = 0; wp0 = wr_pulses; bh0 = b_hs;
    push_wr(32'h24, 32'h0BADCAFE, 4'hF, ok);
    @(posedge clk); #1;
    chk("wstall_both_valid", {AXI_AWVALID, AXI_WVALID}, 2'b11);
    @(posedge clk); #1;
    chk("wstall_aw_drops_first", {AXI_AWVALID, AXI_WVALID}, 2'b01);
    repeat (2) begin @(posedge clk); #1; end
    chk("wstall_w_held", AXI_WVALID, 1);
    w_rdy = 1;
    @(posedge clk); #1;
    chk("wstall_w_drops", AXI_WVALID, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("wstall_one_b_hs", b_hs - bh0, 1);
    chk("wstall_one_pulse", wr_pulses - wp0, 1);
    run_cmd(0, 32'h24, 32'h0, 4'h0, lat, resp, rdat, vn1, oc);
    chk("wstall_readback", rdat, 32'h0BADCAFE);

    // Five reads queued against a stalled AR channel.
    for (int i = 0; i < 5; i++)
      run_cmd(1, 32'h40 + 4*i, 32'hA0 + i, 4'hF, lat, resp, rdat, vn1, oc);
    ar_rdy = 0; n = 0;
    for (int i = 0; i < 5; i++) begin
      push_rd(32'h40 + 4*i, ok);
      if (ok) n++;
    end
    chk("q5_accepted", n, 5);
    chk("q5_ready_low_full", rd_cmd_ready, 0);
    ar_rdy = 1;
    for (int i = 0; i < 5; i++) begin
      wait_rd(got);
      chk($sformatf("q5_pulse%0d", i), got, 1);
      chk($sformatf("q5_data%0d", i), rd_data, 32'hA0 + i);
    end

    // Concurrent write and read to the same address.
    run_cmd(1, 32'h20, 32'h11112222, 4'hF, lat, resp, rdat, vn1, oc);
    wr_cmd_addr = 32'h20; wr_cmd_data = 32'hCAFEF00D; wr_cmd_strb = 4'hF; wr_cmd_valid = 1;
    rd_cmd_addr = 32'h20; rd_cmd_valid = 1;
    @(posedge clk); #1;
    acc = cyc; wr_cmd_valid = 0; rd_cmd_valid = 0;
    @(posedge clk); #1;
    chk("conc_both_buses", {AXI_AWVALID, AXI_WVALID, AXI_ARVALID}, 3'b111);
    wl = -1; rl = -1; rv = '0;
    for (int k = 0; k < 40; k++) begin
      if (wr_resp_valid && wl < 0) wl = cyc - acc;
      if (rd_resp_valid && rl < 0) begin rl = cyc - acc; rv = rd_data; end
      if (wl >= 0 && rl >= 0) break;
      @(posedge clk); #1;
    end
    chk("conc_wr_lat", wl, 4);
    chk("conc_rd_lat", rl, 3);
    chk("conc_rd_old", rv, 32'h11112222);
    chk("conc_wr_resp", wr_resp, 0);
    run_cmd(0, 32'h20, 32'h0, 4'h0, lat, resp, rdat, vn1, oc);
    chk("conc_readback", rdat, 32'hCAFEF00D);

`ifdef AXI4LM_TIMEOUT_EN
    // Dead slave on AR: watchdog aborts after TIMEOUT cycles.
    ar_rdy = 0; n = 0; got = 0;
    push_rd(32'h10, ok);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (AXI_ARVALID) n++;
      else if (n > 0) begin got = rd_resp_valid; break; end
    end
    chk("to_arvalid_cycles", n, 16);
    chk("to_pulse", got, 1);
    chk("to_resp", rd_resp, 2'b11);
    chk("to_err", timeout_err, 1);
    ar_rdy = 1;
    run_cmd(0, 32'h10, 32'h0, 4'h0, lat, resp, rdat, vn1, oc);
    chk("to_next_resp", resp, 0);
    chk("to_next_data", rdat, 32'hDEADBE11);
`endif

    // Reset while waiting in W_RESP with two writes still queued.
    b_hold = 1;
    push_wr(32'h30, 32'h1, 4'hF, ok);
    push_wr(32'h34, 32'h2, 4'hF, ok);
    push_wr(32'h38, 32'h3, 4'hF, ok);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (!AXI_AWVALID && !AXI_WVALID && AXI_BREADY) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("rst_mid_in_w_resp", got, 1);
    chk("rst_mid_queued", wr_idle, 0);
    wp0 = wr_pulses;
    reset = 1;
    @(posedge clk); #1;
    chk("rst_mid_valids", {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
    chk("rst_mid_idle", wr_idle, 1);
    reset = 0; b_hold = 0;
    repeat (10) begin @(posedge clk); #1; end
    chk("rst_mid_no_pulse", wr_pulses, wp0);
    chk("rst_mid_still_idle", {wr_idle, AXI_AWVALID}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/axi4_lite_master_q.md
# axi4_lite_master_q

Parametrised, queued AXI4-Lite master. It accepts write and read commands over valid/ready command ports into per-direction FIFOs. It executes one AXI transaction at a time per direction, with reads and writes running independently, and returns responses in order as single-cycle pulses. It sits between register-access sequencers or host bridges and an AXI4-Lite interconnect, and adds user byte strobes and an optional stall watchdog.

## Interface
- DW, 32, data width; 32 or 64
- AW, 32, address width
- QDEPTH, 4, command FIFO depth per direction; power of two, 2..16
- TIMEOUT, 1024, watchdog limit in clk cycles; used only with the watchdog macro
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- wr_cmd_addr  in  AW  write address
- wr_cmd_data  in  DW  write data
- wr_cmd_strb  in  DW/8  byte strobes
- wr_cmd_valid / wr_cmd_ready  in/out  1  write command handshake
- wr_resp  out  2  BRESP, or timeout code
- wr_resp_valid  out  1  one-cycle pulse per completed write
- wr_idle  out  1  write FIFO empty and write FSM in W_IDLE
- rd_cmd_addr  in  AW  read address
- rd_cmd_valid / rd_cmd_ready  in/out  1  read command handshake
- rd_data  out  DW  RDATA
- rd_resp  out  2  RRESP, or timeout code
- rd_resp_valid  out  1  one-cycle pulse per completed read
- rd_idle  out  1  read FIFO empty and read FSM in R_IDLE
- timeout_err  out  1  sticky; cleared only by reset
- AXI_AW*, AXI_W*, AXI_B*, AXI_AR*, AXI_R*  standard AXI4-Lite master port set; AWADDR/WDATA/WSTRB/ARADDR are AW/DW/DW/8/AW wide; no PROT

## Operation
- A command is accepted on the cycle where valid && ready. ready = !fifo_full. A command is accepted even when the FIFO pops on the same cycle.
- Write FSM:
  - W_IDLE: when the FIFO is not empty, pop it, load AWADDR/WDATA/WSTRB, assert AWVALID, WVALID and BREADY, go to W_ADDR.
  - W_ADDR: drop AWVALID on the AW handshake and WVALID on the W handshake, in either order or together. When both are done, go to W_RESP.
  - W_RESP: on the B handshake, drop BREADY, drive wr_resp=BRESP, pulse wr_resp_valid, go to W_IDLE.
- Read FSM:
  - R_IDLE: pop the FIFO, load ARADDR, assert ARVALID and RREADY, go to R_WAIT.
  - R_WAIT: drop ARVALID on the AR handshake. On the R handshake, which may share a cycle with the AR handshake, capture RDATA and RRESP, drop RREADY, pulse rd_resp_valid, go to R_IDLE.
- The two directions are fully independent. Responses are returned in command order within each direction.
- rd_data and rd_resp hold their last value between pulses.
- Reset mid-transaction discards both FIFOs and any in-flight transaction. No response pulse is issued for discarded work.

## Timing
- Reset values:
  - All VALID/READY outputs 0.
  - wr_cmd_ready and rd_cmd_ready 1.
  - resp_valid pulses 0, resp 0, rd_data 0, timeout_err 0.
  - wr_idle and rd_idle 1.
  - Address, data and strobe outputs 0.
- The FIFO is first-word-fall-through. A command accepted at cycle N into an empty FIFO with the FSM idle gives AWVALID/ARVALID high at N+1.
- Back-to-back: after a response pulse at cycle M, the next queued command's VALID is high at M+1. This gives one idle bus cycle per transaction minimum.
- A zero-wait-state slave, with READY high and BVALID/RVALID one cycle after the handshake, gives command-to-resp_valid latency 3 cycles for reads and 4 for writes.
- FIFO full: ready=0. A push on a full FIFO cannot occur. A same-cycle pop frees ready on the next cycle only.
- A FIFO pointer wraps modulo QDEPTH. The FIFO holds QDEPTH entries using an extra pointer bit.

## Configuration
- AXI4LM_TIMEOUT_EN defined:
  - A per-direction counter starts at 0 on entry to W_ADDR or R_WAIT and increments each cycle the transaction is unfinished.
  - At TIMEOUT, the FSM forcibly drops all VALID/READY for that direction and reports resp=2'b11 (DECERR) with a resp_valid pulse.
  - The FSM sets timeout_err and returns to idle.
  - Any late slave response after the abort is ignored. This deliberately breaks the protocol to recover from a dead slave.
- AXI4LM_TIMEOUT_EN undefined: no counters; FSMs wait indefinitely; timeout_err tied 0.

## Structure
- Package axi4lm_pkg holds:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - The write-state enum (W_IDLE, W_ADDR, W_RESP).
  - The read-state enum (R_IDLE, R_WAIT).
- Sub-module amci_cmd_fifo is a parametrised FWFT sync FIFO, with width and depth set per instance. It is instantiated twice: the write FIFO is AW+DW+DW/8 wide and the read FIFO is AW wide.

## Test plan
- Single write, addr 0x10, data 0xDEADBEEF, strb 0xF, zero-wait slave -> AW/W at N+1, wr_resp_valid at N+4, wr_resp=0, wr_idle high after.
- Slave holds WREADY 3 cycles after AWREADY -> AWVALID drops first, WVALID after 3 cycles, exactly one B handshake and one pulse.
- Push 5 reads with QDEPTH=4 while ARREADY=0 -> rd_cmd_ready low after 4 accepts (the FSM holds the 1st), 5 pulses in order with matching data.
- Concurrent write to 0x20 and read from 0x20 -> both buses active in the same cycles, responses independent.
- AXI4LM_TIMEOUT_EN with TIMEOUT=16 and the slave never asserting ARREADY -> ARVALID drops after 16 cycles, rd_resp=3, timeout_err=1, next read proceeds normally.
- Reset asserted in W_RESP with 2 writes queued -> all VALID/READY 0 the next cycle, no wr_resp_valid, wr_idle=1.
